// File: rtl/i2c_pkg.sv
// Shared types and constants for the command-level I2C master.
// Provides the transaction state encoding, quarter/bit counts per byte and the
// R/W bit values, plus small state-classification helpers.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR_W,
    ST_REG,
    ST_WDATA,
    ST_RSTART,
    ST_ADDR_R,
    ST_RDATA,
    ST_STOP,
    ST_DONE
  } state_t;

  localparam int QTR_PER_BIT   = 4;
  localparam int BITS_PER_BYTE = 9;  // 8 data bits + ACK slot

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // States that shift a 9-bit byte (data + ACK) on the bus.
  function automatic logic is_byte_state(input state_t st);
    return (st == ST_ADDR_W) || (st == ST_REG) || (st == ST_WDATA) ||
           (st == ST_ADDR_R) || (st == ST_RDATA);
  endfunction

  // Byte states where the slave owns the ACK slot and a high level aborts.
  function automatic logic is_ack_checked(input state_t st);
    return (st == ST_ADDR_W) || (st == ST_REG) || (st == ST_WDATA) ||
           (st == ST_ADDR_R);
  endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period timebase: one-cycle tick every DIV clocks, restartable.
// Latency: first tick DIV cycles after clr. Ports: clk_50M, rst, clr, hold, tick.
// Backpressure: with I2C_CLK_STRETCH_EN defined, hold freezes the count (slave stretch).
module i2c_qtr_tick
  import i2c_pkg::*;
#(
  parameter int DIV = 125
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic clr,
  input  logic hold,
  output logic tick
);

  localparam int CW = 10;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic          freeze;

`ifdef I2C_CLK_STRETCH_EN
  assign freeze = hold;
`else
  logic unused_hold;
  assign unused_hold = hold;
  assign freeze      = 1'b0;
`endif

  assign tick = (cnt == TERM) && !freeze;

  always_ff @(posedge clk_50M) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= (cnt == TERM) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Command-level I2C master: one single-byte register write or read per command.
// Latency: write 116*DIV+1, read 156*DIV+1 cycles from accept to rsp_valid.
// Backpressure: cmd_ready only in IDLE; I2C_CLK_STRETCH_EN lets the slave stretch SCL in Q2.
// Ports: cmd_* request (valid/ready), rsp_* one-cycle response, busy,
// scl_oe/sda_oe open-drain pull-downs, scl_in/sda_in pad levels.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         DIV      = 125
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in
);

  state_t     state;
  logic [1:0] qtr;
  logic [3:0] bit_idx;
  logic       rw_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       nack_q;

  logic       tick;
  logic       accept;
  logic       stretch_hold;

  state_t     nxt_state;
  logic [1:0] nxt_qtr;
  logic [3:0] nxt_bit;
  logic [7:0] tx_byte;
  logic [1:0] nxt_drive;

  assign accept       = (state == ST_IDLE) && cmd_valid;
  // Slave is holding SCL low after we released it in the high phase.
  assign stretch_hold = is_byte_state(state) && (qtr == 2'd2) && !scl_in;

  i2c_qtr_tick #(.DIV(DIV)) u_tick (
    .clk_50M (clk_50M),
    .rst     (rst),
    .clr     (accept),
    .hold    (stretch_hold),
    .tick    (tick)
  );

  // Returns {scl_oe, sda_oe} for a given bus position.
  function automatic logic [1:0] bus_drive(input state_t st, input logic [1:0] q,
                                           input logic [3:0] b, input logic [7:0] tx);
    logic [1:0] d;
    d = 2'b00;
    case (st)
      ST_START: begin
        if (q == 2'd2)      d = 2'b01;
        else if (q == 2'd3) d = 2'b11;
      end
      // SCL is pulled low first so SDA can rise without forming a STOP.
      ST_RSTART: begin
        case (q)
          2'd0:    d = 2'b10;
          2'd1:    d = 2'b00;
          2'd2:    d = 2'b01;
          default: d = 2'b11;
        endcase
      end
      ST_STOP: begin
        case (q)
          2'd0:    d = 2'b11;
          2'd3:    d = 2'b00;
          default: d = 2'b01;
        endcase
      end
      ST_ADDR_W, ST_REG, ST_WDATA, ST_ADDR_R, ST_RDATA: begin
        d[1] = (q < 2'd2);
        // ACK slot and received data bits leave SDA released.
        if ((b < 4'd8) && (st != ST_RDATA)) d[0] = ~tx[3'd7 - b[2:0]];
      end
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  // Position of the bus after the next quarter tick.
  always_comb begin
    nxt_state = state;
    nxt_qtr   = qtr + 2'd1;
    nxt_bit   = bit_idx;
    if (qtr == 2'd3) begin
      nxt_qtr = 2'd0;
      if (is_byte_state(state)) begin
        if (bit_idx == 4'(BITS_PER_BYTE - 1)) begin
          nxt_bit = 4'd0;
          if (nack_q) begin
            nxt_state = ST_STOP;
          end else begin
            case (state)
              ST_ADDR_W: nxt_state = ST_REG;
              ST_REG:    nxt_state = (rw_q == RW_READ) ? ST_RSTART : ST_WDATA;
              ST_ADDR_R: nxt_state = ST_RDATA;
              default:   nxt_state = ST_STOP;
            endcase
          end
        end else begin
          nxt_bit = bit_idx + 4'd1;
        end
      end else begin
        nxt_bit = 4'd0;
        case (state)
          ST_START:  nxt_state = ST_ADDR_W;
          ST_RSTART: nxt_state = ST_ADDR_R;
          ST_STOP:   nxt_state = ST_DONE;
          default:   nxt_state = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    case (nxt_state)
      ST_ADDR_W: tx_byte = {DEV_ADDR, RW_WRITE};
      ST_REG:    tx_byte = reg_q;
      ST_WDATA:  tx_byte = wdata_q;
      ST_ADDR_R: tx_byte = {DEV_ADDR, RW_READ};
      default:   tx_byte = 8'h00;
    endcase
    nxt_drive = bus_drive(nxt_state, nxt_qtr, nxt_bit, tx_byte);
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state     <= ST_IDLE;
      qtr       <= 2'd0;
      bit_idx   <= 4'd0;
      rw_q      <= RW_WRITE;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      nack_q    <= 1'b0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_nack  <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            rw_q      <= cmd_rw;
            reg_q     <= cmd_reg;
            wdata_q   <= cmd_wdata;
            rdata_q   <= 8'h00;
            nack_q    <= 1'b0;
            qtr       <= 2'd0;
            bit_idx   <= 4'd0;
            state     <= ST_START;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_nack  <= nack_q;
          rsp_rdata <= ((rw_q == RW_READ) && !nack_q) ? rdata_q : 8'h00;
        end
        default: begin
          if (tick) begin
            // SDA is sampled on the tick that ends the first SCL-high quarter.
            if (qtr == 2'd2) begin
              if (is_ack_checked(state) && (bit_idx == 4'd8) && sda_in)
                nack_q <= 1'b1;
              if ((state == ST_RDATA) && (bit_idx < 4'd8))
                rdata_q <= {rdata_q[6:0], sda_in};
            end
            state   <= nxt_state;
            qtr     <= nxt_qtr;
            bit_idx <= nxt_bit;
            scl_oe  <= nxt_drive[1];
            sda_oe  <= nxt_drive[0];
          end
        end
      endcase
    end
  end

endmodule
